// File: rtl/riscv_pkg.sv
// Shared integer-datapath types and constants for the writeback path.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; push ignored when full, pop ignored when empty.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push,
  input  wb_entry_t     din,
  input  logic          pop,
  output wb_entry_t     dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[head_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + AW'(1);
      if (do_pop)  head_q <= head_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= din;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port owner: ALU/long-latency arbitration, result buffer, pending scoreboard.
module writeback_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [REG_AW-1:0] ll_rd,
  input  logic [XLEN-1:0]   ll_data,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  input  logic [REG_AW-1:0] q_rd,
  output logic              hazard,
  output logic              RegWr,
  output logic [REG_AW-1:0] write_reg,
  output logic [XLEN-1:0]   write_data
);

  localparam int unsigned NREG = 1 << REG_AW;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t         fifo_din, fifo_head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              alu_win;

  logic              regwr_q, regwr_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic [XLEN-1:0]   write_data_q, write_data_d;
  logic [NREG-1:0]   pend_q, pend_d;

  assign alu_win   = alu_valid && (alu_rd != REG_ZERO);
  assign fifo_pop  = !alu_win && !fifo_empty;
  assign ll_ready  = (fifo_count != CW'(FIFO_DEPTH));
  // x0 results complete the handshake but are never buffered.
  assign fifo_push = ll_valid && !fifo_full && (ll_rd != REG_ZERO);
  assign fifo_din  = '{rd: ll_rd, data: ll_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    regwr_d      = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (alu_win) begin
      regwr_d      = 1'b1;
      write_reg_d  = alu_rd;
      write_data_d = alu_data;
    end else if (fifo_pop) begin
      regwr_d      = 1'b1;
      write_reg_d  = fifo_head.rd;
      write_data_d = fifo_head.data;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register pending.
  always_comb begin
    pend_d = pend_q;
    if (fifo_pop) pend_d[fifo_head.rd] = 1'b0;
    if (issue_valid && (issue_rd != REG_ZERO)) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      regwr_q      <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pend_q       <= '0;
    end else begin
      regwr_q      <= regwr_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pend_q       <= pend_d;
    end
  end

  assign hazard     = pend_q[q_rs1] | pend_q[q_rs2] | pend_q[q_rd];
  assign RegWr      = regwr_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a write-order scoreboard and scoreboard-bit model.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ll_valid = 1'b0;
  logic        ll_ready;
  logic [4:0]  ll_rd = '0;
  logic [31:0] ll_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  q_rs1 = '0, q_rs2 = '0, q_rd = '0;
  logic        hazard;
  logic        RegWr;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  writeback_arbiter #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ll_valid    (ll_valid),
    .ll_ready    (ll_ready),
    .ll_rd       (ll_rd),
    .ll_data     (ll_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .q_rs1       (q_rs1),
    .q_rs2       (q_rs2),
    .q_rd        (q_rd),
    .hazard      (hazard),
    .RegWr       (RegWr),
    .write_reg   (write_reg),
    .write_data  (write_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  int          compared = 0;
  int          mismatched = 0;
  wr_t         exp_q[$];
  wr_t         ll_m[$];
  logic [31:0] pend_m = '0;
  logic [4:0]  last_reg = '0;
  logic [31:0] last_data = '0;
  bit          ll_acc;
  int          k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic haz_m();
    return pend_m[q_rs1] | pend_m[q_rs2] | pend_m[q_rd];
  endfunction

  // One clock: check combinational outputs, advance the model, then check the write port.
  task automatic cycle();
    logic        win;
    logic        full_m;
    logic [31:0] nxt;
    wr_t         e;
    #1;
    full_m = (ll_m.size() == 4);
    chk("ll_ready", ll_ready, !full_m);
    chk("hazard", hazard, haz_m());
    win = 1'b1;
    nxt = pend_m;
    if (alu_valid && alu_rd != 5'd0) begin
      exp_q.push_back('{rd: alu_rd, data: alu_data});
    end else if (ll_m.size() != 0) begin
      e = ll_m.pop_front();
      nxt[e.rd] = 1'b0;
      exp_q.push_back(e);
    end else begin
      win = 1'b0;
    end
    ll_acc = ll_valid && !full_m;
    if (ll_acc && ll_rd != 5'd0) ll_m.push_back('{rd: ll_rd, data: ll_data});
    if (issue_valid && issue_rd != 5'd0) nxt[issue_rd] = 1'b1;
    nxt[0] = 1'b0;
    pend_m = nxt;
    @(posedge clk);
    #1;
    chk("RegWr", RegWr, win);
    if (win) begin
      e = exp_q.pop_front();
      last_reg  = e.rd;
      last_data = e.data;
    end
    chk("write_reg", write_reg, last_reg);
    chk("write_data", write_data, last_data);
  endtask

  initial begin
    // Reset values while n_rst is held low.
    q_rs1 = 5'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_RegWr", RegWr, 0);
    chk("rst_write_reg", write_reg, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_ll_ready", ll_ready, 1);
    chk("rst_hazard", hazard, 0);
    n_rst = 1'b1;
    q_rs1 = 5'd0;

    // ALU path.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    alu_valid = 1'b0;
    cycle();

    // x0 suppression: ALU rd=0 does not block a pop; LL rd=0 is dropped.
    issue_valid = 1'b1; issue_rd = 5'd3; q_rs1 = 5'd3;
    ll_valid = 1'b1; ll_rd = 5'd3; ll_data = 32'h11;
    cycle();
    issue_valid = 1'b0; ll_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD00000;
    cycle();
    alu_valid = 1'b0;
    cycle();
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'hBAD00001;
    cycle();
    ll_valid = 1'b0; q_rs1 = 5'd0;
    repeat (2) cycle();

    // Contention: ALU busy for 8 cycles while 5 LL results are offered.
    k = 0;
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = $urandom;
      ll_valid = (k < 5); ll_rd = 5'(10 + k); ll_data = 32'hA0000000 + k;
      cycle();
      if (ll_acc) k++;
    end
    alu_valid = 1'b0;
    for (int j = 0; j < 20 && (k < 5 || ll_m.size() != 0); j++) begin
      ll_valid = (k < 5); ll_rd = 5'(10 + k); ll_data = 32'hA0000000 + k;
      cycle();
      if (ll_acc) k++;
    end
    ll_valid = 1'b0;
    cycle();
    chk("ll_all_accepted", k, 5);

    // Scoreboard set/clear through all three query ports.
    q_rs1 = 5'd7; issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    issue_valid = 1'b0;
    cycle();
    q_rs1 = 5'd0; q_rs2 = 5'd7;
    cycle();
    q_rs2 = 5'd0; q_rd = 5'd7;
    cycle();
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h77;
    cycle();
    ll_valid = 1'b0; q_rd = 5'd0; q_rs1 = 5'd7;
    cycle();
    cycle();
    q_rs1 = 5'd0;

    // Set/clear collision on rd=9: set wins.
    issue_valid = 1'b1; issue_rd = 5'd9;
    cycle();
    issue_valid = 1'b0;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h99;
    cycle();
    ll_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9; q_rs1 = 5'd9;
    cycle();
    issue_valid = 1'b0;
    cycle();
    chk("hazard_collision", hazard, 1);
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9A;
    cycle();
    ll_valid = 1'b0;
    repeat (2) cycle();
    q_rs1 = 5'd0;

    // Reset mid-operation with 3 buffered entries and pend[4] set.
    issue_valid = 1'b1; issue_rd = 5'd4;
    cycle();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      ll_valid = 1'b1; ll_rd = 5'(20 + i); ll_data = 32'hC0 + i;
      cycle();
    end
    ll_valid = 1'b0; q_rs1 = 5'd4;
    #2;
    n_rst = 1'b0;
    #1;
    chk("midrst_RegWr", RegWr, 0);
    chk("midrst_write_reg", write_reg, 0);
    chk("midrst_write_data", write_data, 0);
    chk("midrst_ll_ready", ll_ready, 1);
    chk("midrst_hazard", hazard, 0);
    ll_m.delete();
    exp_q.delete();
    pend_m = '0; last_reg = '0; last_data = '0;
    alu_valid = 1'b0;
    #2;
    n_rst = 1'b1;
    repeat (5) cycle();
    q_rs1 = 5'd0;

    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
